// File: rtl/hamming_symbol_encoder.sv
// hamming_symbol_encoder
//
// Streaming Hamming encoder for the FEC transmit path. Each accepted message
// is encoded into a Hamming codeword that is zero-padded to CODE_WIDTH bits.
// The codeword is then sent to the modulator as CODE_WIDTH/SYMBOL_WIDTH
// symbols, least-significant symbol first.
//
// Optional feature: define SECDED_EN to place overall even parity at
// codeword bit N (N = DATA_WIDTH+PARITY_BITS), giving SECDED. Without it,
// bit N stays 0 and the code is plain SEC.
//
// Ports:
//   clk        in   clock, all state changes on posedge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   message present on in_data
//   in_ready   out  encoder accepts a message this cycle
//   in_data    in   [DATA_WIDTH-1:0] message
//   out_valid  out  symbol present on out_data
//   out_ready  in   modulator consumes the symbol this cycle
//   out_data   out  [SYMBOL_WIDTH-1:0] current symbol
//   out_last   out  final symbol of the current codeword
//   words_sent out  [15:0] completed codewords, wraps at 0xFFFF
module hamming_symbol_encoder #(
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_BITS  = 4,
    parameter int CODE_WIDTH   = 16,
    parameter int SYMBOL_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SYMBOL_WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic [15:0]             words_sent
);

    localparam int N       = DATA_WIDTH + PARITY_BITS;
    localparam int SYMBOLS = CODE_WIDTH / SYMBOL_WIDTH;
    localparam int CNT_W   = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMBOLS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    // Codeword position k (1-based) lives in bit k-1. Data bits fill the
    // non-power-of-two positions in ascending order. Check bit i (position
    // 2^i) covers every position whose index has bit i set. Parity positions
    // are still zero while the checks are computed, so they do not disturb
    // each other.
    function automatic logic [CODE_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] d);
        logic [CODE_WIDTH-1:0] cw;
        logic [CODE_WIDTH-1:0] mask;
        logic [DATA_WIDTH-1:0] dsh;
        logic                  p;
        cw  = '0;
        dsh = d;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw  = cw | (CODE_WIDTH'(dsh[0]) << (pos - 1));
                dsh = dsh >> 1;
            end
        end
        for (int i = 0; i < PARITY_BITS; i++) begin
            mask = '0;
            for (int pos = 1; pos <= N; pos++) begin
                if (((pos >> i) % 2) != 0) begin
                    mask = mask | (CODE_WIDTH'(1) << (pos - 1));
                end
            end
            p  = ^(cw & mask);
            cw = cw | (CODE_WIDTH'(p) << ((1 << i) - 1));
        end
`ifdef SECDED_EN
        // Only bits 0..N-1 can be set here, so reducing all of cw gives the
        // overall parity of the SEC codeword.
        cw = cw | (CODE_WIDTH'(^cw) << N);
`else
`endif
        return cw;
    endfunction

    state_t                  state_q, state_d;
    logic [CODE_WIDTH-1:0]   s1_q, s1_d;
    logic                    s1_valid_q, s1_valid_d;
    logic [CODE_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        sym_cnt_q, sym_cnt_d;
    logic [15:0]             words_q, words_d;

    logic sym_hs;
    logic at_last;
    logic take_s1;
    logic accept;

    always_comb begin
        sym_hs  = (state_q == SHIFT) && out_ready;
        at_last = (state_q == SHIFT) && (sym_cnt_q == LAST_CNT);
        // Stage 2 takes the stage-1 word when idle, or on the handshake of
        // the final symbol, so consecutive codewords leave no bubble.
        take_s1  = s1_valid_q && ((state_q == IDLE) || (sym_hs && at_last));
        in_ready = !s1_valid_q || take_s1;
        accept   = in_valid && in_ready;

        // Stage 1: encode register
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        if (take_s1) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_d       = encode(in_data);
            s1_valid_d = 1'b1;
        end

        // Stage 2: serializer
        state_d   = state_q;
        shift_d   = shift_q;
        sym_cnt_d = sym_cnt_q;
        words_d   = words_q;
        case (state_q)
            IDLE: begin
                if (s1_valid_q) begin
                    state_d   = SHIFT;
                    shift_d   = s1_q;
                    sym_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (sym_hs) begin
                    if (at_last) begin
                        words_d   = words_q + 16'd1;
                        sym_cnt_d = '0;
                        if (s1_valid_q) begin
                            shift_d = s1_q;
                        end else begin
                            state_d = IDLE;
                            shift_d = '0;
                        end
                    end else begin
                        shift_d   = shift_q >> SYMBOL_WIDTH;
                        sym_cnt_d = sym_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            shift_q    <= '0;
            sym_cnt_q  <= '0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            shift_q    <= shift_d;
            sym_cnt_q  <= sym_cnt_d;
            words_q    <= words_d;
        end
    end

    assign out_valid  = (state_q == SHIFT);
    assign out_data   = shift_q[SYMBOL_WIDTH-1:0];
    assign out_last   = at_last;
    assign words_sent = words_q;

endmodule

// File: tb/tb_hamming_symbol_encoder.sv
`timescale 1ns/1ps
module tb_hamming_symbol_encoder;

    localparam int DW   = 8;
    localparam int PB   = 4;
    localparam int CW   = 16;
    localparam int SW   = 4;
    localparam int NSYM = CW / SW;
    localparam int NPOS = DW + PB;
`ifdef SECDED_EN
    localparam logic [CW-1:0] EXP01 = 16'h1007;
`else
    localparam logic [CW-1:0] EXP01 = 16'h0007;
`endif
    localparam logic [CW-1:0] EXPA5 = 16'h0A27;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] out_data;
    logic          out_last;
    logic [15:0]   words_sent;

    always #5 clk = ~clk;

    hamming_symbol_encoder #(
        .DATA_WIDTH(DW), .PARITY_BITS(PB), .CODE_WIDTH(CW), .SYMBOL_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .words_sent(words_sent)
    );

    int           total = 0;
    int           bad = 0;
    logic [SW:0]  exp_q[$];
    logic [15:0]  exp_words = 16'd0;
    int           hs_count = 0;
    logic [SW:0]  mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder built from the codeword rules: an array indexed by
    // 1-based position, data dealt into non-power-of-two slots, check bits
    // counted as sums modulo 2.
    function automatic logic [CW-1:0] model(input logic [DW-1:0] d);
        int bitv[NPOS+1];
        int dv;
        int k;
        int par;
        logic [CW-1:0] cw;
        dv = int'(d);
        k  = 0;
        cw = '0;
        for (int p = 0; p <= NPOS; p++) bitv[p] = 0;
        for (int p = 1; p <= NPOS; p++) begin
            if ((p & (p - 1)) != 0) begin
                bitv[p] = (dv >> k) & 1;
                k++;
            end
        end
        for (int i = 0; i < PB; i++) begin
            par = 0;
            for (int p = 1; p <= NPOS; p++)
                if (((p >> i) & 1) == 1 && p != (1 << i)) par += bitv[p];
            bitv[1 << i] = par % 2;
        end
        for (int p = 1; p <= NPOS; p++) cw = cw | (CW'(bitv[p]) << (p - 1));
`ifdef SECDED_EN
        par = 0;
        for (int p = 1; p <= NPOS; p++) par += bitv[p];
        cw = cw | (CW'(par % 2) << NPOS);
`endif
        return cw;
    endfunction

    task automatic push_word(input logic [CW-1:0] cw);
        logic [SW-1:0] sy;
        logic          lst;
        for (int s = 0; s < NSYM; s++) begin
            sy  = SW'(cw >> (s * SW));
            lst = (s == NSYM - 1);
            exp_q.push_back({lst, sy});
        end
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] cw);
        bit ok;
        ok = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int t = 0; t < 2000 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                push_word(cw);
                ok = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 want 1 for data %0h", d);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_words", words_sent, exp_words);
    endtask

    // Monitor: every accepted symbol is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            hs_count++;
            check("words_sent", words_sent, exp_words);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sym_unexpected: got %0h want none", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sym", out_data, mon_e[SW-1:0]);
                check("last", out_last, mon_e[SW]);
                if (mon_e[SW]) exp_words = exp_words + 16'd1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int run;
        logic [SW-1:0] hd;
        logic          hl;
        logic [DW-1:0] rd;
        int            gap;
        bit            sdone;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_words", words_sent, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);

        // Directed codewords and first-symbol latency
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'h01, EXP01);
        @(negedge clk);
        check("lat_before", out_valid, 0);
        @(negedge clk);
        check("lat_first", out_valid, 1);
        drain();
        @(posedge clk); #1;
        send(8'hA5, EXPA5);
        drain();

        // Back-to-back stream with no bubble
        @(posedge clk); #1;
        fork
            begin
                send(8'h00, model(8'h00));
                send(8'h01, EXP01);
                send(8'hA5, EXPA5);
            end
            begin
                run = 0;
                for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
                for (int i = 0; i < 12; i++) begin
                    if (out_valid) run++;
                    @(negedge clk);
                end
                check("b2b_run", run, 12);
                check("b2b_end", out_valid, 0);
            end
        join
        drain();

        // Back-pressure mid-word
        @(posedge clk); #1;
        base = hs_count;
        fork
            begin
                send(8'h3C, model(8'h3C));
                send(8'hC3, model(8'hC3));
                send(8'h5A, model(8'h5A));
            end
            begin
                for (int t = 0; t < 100 && hs_count < base + 2; t++) @(negedge clk);
                @(posedge clk); #1;
                out_ready = 1'b0;
                @(negedge clk);
                hd = out_data;
                hl = out_last;
                check("stall_sym", out_data, exp_q[0][SW-1:0]);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("stall_data", out_data, hd);
                    check("stall_last", out_last, hl);
                    check("stall_valid", out_valid, 1);
                    check("stall_in_ready", in_ready, 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset in the middle of a word
        @(posedge clk); #1;
        base = hs_count;
        send(8'hA5, EXPA5);
        for (int t = 0; t < 100 && hs_count < base + 2; t++) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_words", words_sent, 0);
        exp_q.delete();
        exp_words = 16'd0;
        repeat (2) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_in_ready", in_ready, 1);
        @(posedge clk); #1;
        send(8'h01, EXP01);
        drain();
        check("mid_rst_one_word", words_sent, 1);

        // Randomized traffic with random back-pressure
        sdone = 1'b0;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    rd  = 8'($urandom);
                    gap = $urandom_range(0, 2);
                    repeat (gap) begin @(posedge clk); #1; end
                    send(rd, model(rd));
                end
                sdone = 1'b1;
            end
            begin
                while (!sdone) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Counter wrap: preload near the top, then complete three words
        @(posedge clk); #1;
        force dut.words_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.words_q;
        exp_words = 16'hFFFE;
        send(8'h11, model(8'h11));
        send(8'h22, model(8'h22));
        send(8'h33, model(8'h33));
        drain();
        check("wrap_words", words_sent, 16'h0001);

        check("final_queue", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
